// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the IF
// fetch and the MEM-stage load/store. One transaction is in flight at a time.
// The data side wins ties, except when fetch has already lost STARVE_MAX
// consecutive ties. Then fetch is served next.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   MEM_LAT     cycles from issue (mem_en=1) to mem_rdata valid, 1..8
//   STARVE_MAX  max consecutive data grants while if_req waits, 1..15
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst_n       synchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//   if_req      fetch request, held with a stable if_addr until if_rvalid
//   if_addr     fetch address
//   if_gnt      pulse: fetch issued to memory this cycle
//   if_rvalid   pulse: if_rdata valid
//   if_rdata    fetched word; 0 when if_rvalid=0
//   dm_req      data request, held stable until dm_rvalid
//   dm_we       1 = store, 0 = load
//   dm_addr     data address
//   dm_wdata    store data
//   dm_gnt      pulse: data access issued this cycle
//   dm_rvalid   pulse: load data valid / store complete
//   dm_rdata    load data; 0 when dm_rvalid=0 or for a store
//   mem_en      memory access strobe, one cycle per transaction
//   mem_we      memory write enable, only asserted with mem_en
//   mem_addr    memory address; 0 when mem_en=0
//   mem_wdata   memory write data; 0 unless a store is issued
//   mem_rdata   memory read data, valid MEM_LAT cycles after issue
//   stall_f     if_req & ~if_rvalid
//   stall_m     dm_req & ~dm_rvalid
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_f,
    output logic              stall_m
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
    localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]       state;
    logic [LAT_W-1:0] lat_cnt;
    logic [3:0]       starve_cnt;
    logic             txn_store;   // in-flight data transaction is a store

    logic in_reset;
    logic can_issue;
    logic fetch_wins;
    logic issue_i;
    logic issue_d;
    logic done;

    // -----------------------------------------------------------------------
    // Arbitration and issue (combinational, same cycle as the request)
    // -----------------------------------------------------------------------
    always_comb begin
        in_reset   = rst_n;
        can_issue  = (state == S_IDLE) && !in_reset;
        // Fetch takes a contested slot only after too many data wins.
        fetch_wins = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
        issue_i    = can_issue && fetch_wins;
        issue_d    = can_issue && dm_req && !fetch_wins;
        // Completion is the last busy cycle. It is masked while reset is
        // asserted, so a discarded transaction never reports rvalid.
        done       = !in_reset && (state != S_IDLE) && (lat_cnt == LAT_ONE);
    end

    always_comb begin
        mem_en    = issue_i || issue_d;
        mem_we    = issue_d && dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_d) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (issue_i) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        if_gnt    = issue_i;
        dm_gnt    = issue_d;
        if_rvalid = done && (state == S_BUSY_I);
        dm_rvalid = done && (state == S_BUSY_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = (dm_rvalid && !txn_store) ? mem_rdata : '0;
        stall_f   = if_req && !if_rvalid;
        stall_m   = dm_req && !dm_rvalid;
    end

    // -----------------------------------------------------------------------
    // State, latency counter and starvation counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            txn_store  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_i) begin
                        state      <= S_BUSY_I;
                        lat_cnt    <= LAT_LOAD;
                        starve_cnt <= '0;
                        txn_store  <= 1'b0;
                    end else if (issue_d) begin
                        state     <= S_BUSY_D;
                        lat_cnt   <= LAT_LOAD;
                        txn_store <= dm_we;
                        if (if_req && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    // lat_cnt==0 cannot occur while busy. Treat it as done
                    // so the FSM can never lock up.
                    if (lat_cnt <= LAT_ONE) begin
                        state   <= S_IDLE;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_ONE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    lat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // ---------------- DUT A: MEM_LAT=1, STARVE_MAX=2 ----------------
    logic        rst_a;
    logic        if_req_a, dm_req_a, dm_we_a;
    logic [31:0] if_addr_a, dm_addr_a, dm_wdata_a;
    logic        if_gnt_a, if_rvalid_a, dm_gnt_a, dm_rvalid_a;
    logic [31:0] if_rdata_a, dm_rdata_a;
    logic        mem_en_a, mem_we_a, stall_f_a, stall_m_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) u_a (
        .clk(clk), .rst_n(rst_a),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
        .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
        .dm_gnt(dm_gnt_a), .dm_rvalid(dm_rvalid_a), .dm_rdata(dm_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .stall_f(stall_f_a), .stall_m(stall_m_a)
    );

    // ---------------- DUT B: MEM_LAT=3, STARVE_MAX=4 ----------------
    logic        rst_b;
    logic        if_req_b, dm_req_b, dm_we_b;
    logic [31:0] if_addr_b, dm_addr_b, dm_wdata_b;
    logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b;
    logic [31:0] if_rdata_b, dm_rdata_b;
    logic        mem_en_b, mem_we_b, stall_f_b, stall_m_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
        .clk(clk), .rst_n(rst_b),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
        .dm_gnt(dm_gnt_b), .dm_rvalid(dm_rvalid_b), .dm_rdata(dm_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .stall_f(stall_f_b), .stall_m(stall_m_b)
    );

    // Contents of any location that has not been written
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory models ----------------
    logic [31:0] mem_a [logic [31:0]];
    logic [31:0] mem_b [logic [31:0]];
    logic [31:0] rd_a;
    logic [31:0] p0_b, p1_b, p2_b;

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = p2_b;

    always @(posedge clk) begin
        if (mem_en_a) begin
            rd_a <= mem_a.exists(mem_addr_a) ? mem_a[mem_addr_a] : dflt(mem_addr_a);
            if (mem_we_a) mem_a[mem_addr_a] = mem_wdata_a;
        end
    end

    always @(posedge clk) begin
        if (mem_en_b) begin
            p0_b <= mem_b.exists(mem_addr_b) ? mem_b[mem_addr_b] : dflt(mem_addr_b);
            if (mem_we_b) mem_b[mem_addr_b] = mem_wdata_b;
        end
        p1_b <= p0_b;
        p2_b <= p1_b;
    end

    // ---------------- scoreboards ----------------
    logic [31:0] ref_a [logic [31:0]];
    logic [31:0] iq_a[$], dq_a[$], iq_b[$];

    always @(negedge clk) begin : mon_a
        logic [31:0] e;
        if (rst_a) begin
            iq_a.delete();
            dq_a.delete();
        end else begin
            if (if_gnt_a)
                iq_a.push_back(ref_a.exists(if_addr_a) ? ref_a[if_addr_a] : dflt(if_addr_a));
            if (dm_gnt_a) begin
                if (dm_we_a) begin
                    dq_a.push_back(32'h0);
                    ref_a[dm_addr_a] = dm_wdata_a;
                end else begin
                    dq_a.push_back(ref_a.exists(dm_addr_a) ? ref_a[dm_addr_a] : dflt(dm_addr_a));
                end
            end
            if (if_rvalid_a) begin
                if (iq_a.size() == 0) chk("a_if_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = iq_a.pop_front();
                    chk("a_if_rdata", {32'h0, if_rdata_a}, {32'h0, e});
                end
            end else begin
                chk("a_if_rdata_idle", {32'h0, if_rdata_a}, 64'h0);
            end
            if (dm_rvalid_a) begin
                if (dq_a.size() == 0) chk("a_dm_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = dq_a.pop_front();
                    chk("a_dm_rdata", {32'h0, dm_rdata_a}, {32'h0, e});
                end
            end
            if (!mem_en_a)
                chk("a_mem_bus_idle", {mem_addr_a, mem_wdata_a}, 64'h0);
        end
    end

    always @(negedge clk) begin : mon_b
        logic [31:0] e;
        if (rst_b) begin
            iq_b.delete();
        end else begin
            if (if_gnt_b) iq_b.push_back(dflt(if_addr_b));
            if (if_rvalid_b) begin
                if (iq_b.size() == 0) chk("b_if_unexpected_rvalid", 64'd1, 64'd0);
                else begin
                    e = iq_b.pop_front();
                    chk("b_if_rdata", {32'h0, if_rdata_b}, {32'h0, e});
                end
            end
        end
    end

    // ---------------- vector table for DUT A ----------------
    // exp bits: {mem_en, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid, stall_f, stall_m}
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [7:0] ex);
        vec_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.exp = ex;
        vq.push_back(v);
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;

        // simple fetch
        add(1, 32'h40, 0, 0, 32'h0,   32'h0, 8'b1010_0010);
        add(1, 32'h40, 0, 0, 32'h0,   32'h0, 8'b0000_1000);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);
        // fetch and load together: data first
        add(1, 32'h44, 1, 0, 32'h100, 32'h0, 8'b1001_0011);
        add(1, 32'h44, 1, 0, 32'h100, 32'h0, 8'b0000_0110);
        add(1, 32'h44, 0, 0, 32'h0,   32'h0, 8'b1010_0010);
        add(1, 32'h44, 0, 0, 32'h0,   32'h0, 8'b0000_1000);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);
        // starvation bound 2: D, D, then I
        add(1, 32'h48, 1, 0, 32'h104, 32'h0, 8'b1001_0011);
        add(1, 32'h48, 1, 0, 32'h104, 32'h0, 8'b0000_0110);
        add(1, 32'h48, 1, 0, 32'h108, 32'h0, 8'b1001_0011);
        add(1, 32'h48, 1, 0, 32'h108, 32'h0, 8'b0000_0110);
        add(1, 32'h48, 1, 0, 32'h10C, 32'h0, 8'b1010_0011);
        add(1, 32'h48, 1, 0, 32'h10C, 32'h0, 8'b0000_1001);
        add(0, 32'h0,  1, 0, 32'h10C, 32'h0, 8'b1001_0001);
        add(0, 32'h0,  1, 0, 32'h10C, 32'h0, 8'b0000_0100);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);
        // store then load back
        add(0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 8'b1101_0001);
        add(0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 8'b0000_0100);
        add(0, 32'h0,  1, 0, 32'h200, 32'h0, 8'b1001_0001);
        add(0, 32'h0,  1, 0, 32'h200, 32'h0, 8'b0000_0100);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);
        // fetch raised for one cycle during a data access, then abandoned
        add(0, 32'h0,  1, 0, 32'h110, 32'h0, 8'b1001_0001);
        add(1, 32'h4C, 1, 0, 32'h110, 32'h0, 8'b0000_0110);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);
        // starvation counter was cleared by the fetch issue: data wins again
        add(1, 32'h50, 1, 0, 32'h114, 32'h0, 8'b1001_0011);
        add(1, 32'h50, 1, 0, 32'h114, 32'h0, 8'b0000_0110);
        add(1, 32'h50, 0, 0, 32'h0,   32'h0, 8'b1010_0010);
        add(1, 32'h50, 0, 0, 32'h0,   32'h0, 8'b0000_1000);
        add(0, 32'h0,  0, 0, 32'h0,   32'h0, 8'b0000_0000);

        // both requests high during reset: nothing issued, stalls follow req
        rst_a = 1; rst_b = 1;
        if_req_a = 1; if_addr_a = 32'h40; dm_req_a = 1; dm_we_a = 0;
        dm_addr_a = 32'h100; dm_wdata_a = 0;
        if_req_b = 0; if_addr_b = 0; dm_req_b = 0; dm_we_b = 0; dm_addr_b = 0; dm_wdata_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a_reset_outputs",
            {59'h0, mem_en_a, if_gnt_a, dm_gnt_a, if_rvalid_a, dm_rvalid_a}, 64'h0);
        chk("a_reset_stalls", {62'h0, stall_f_a, stall_m_a}, 64'h3);

        foreach (vq[k]) begin
            v = vq[k];
            @(posedge clk);
            #1;
            rst_a      = 0;
            if_req_a   = v.i_req;
            if_addr_a  = v.i_addr;
            dm_req_a   = v.d_req;
            dm_we_a    = v.d_we;
            dm_addr_a  = v.d_addr;
            dm_wdata_a = v.d_wdata;
            @(negedge clk);
            chk($sformatf("row%0d_ctrl", k),
                {56'h0, mem_en_a, mem_we_a, if_gnt_a, dm_gnt_a,
                 if_rvalid_a, dm_rvalid_a, stall_f_a, stall_m_a},
                {56'h0, v.exp});
            if (v.exp[7]) begin
                chk($sformatf("row%0d_addr", k), {32'h0, mem_addr_a},
                    {32'h0, (v.exp[5] ? v.i_addr : v.d_addr)});
                if (v.exp[6])
                    chk($sformatf("row%0d_wdata", k), {32'h0, mem_wdata_a}, {32'h0, v.d_wdata});
            end
        end

        // ---------- MEM_LAT=3: reset one cycle after a fetch grant ----------
        @(posedge clk); #1;
        rst_b = 0;
        @(negedge clk);
        chk("b_idle_no_en", {63'h0, mem_en_b}, 64'h0);

        @(posedge clk); #1;
        if_req_b = 1; if_addr_b = 32'h40;
        @(negedge clk);
        chk("b_first_gnt", {62'h0, if_gnt_b, stall_f_b}, 64'h3);

        @(posedge clk); #1;
        rst_b = 1;
        @(negedge clk);
        chk("b_in_reset_outputs",
            {59'h0, mem_en_b, if_gnt_b, dm_gnt_b, if_rvalid_b, dm_rvalid_b}, 64'h0);
        chk("b_in_reset_stall_f", {63'h0, stall_f_b}, 64'h1);

        @(posedge clk); #1;
        rst_b = 0; if_addr_b = 32'h80;
        @(negedge clk);
        chk("b_regrant", {62'h0, if_gnt_b, mem_en_b}, 64'h3);
        chk("b_regrant_addr", {32'h0, mem_addr_b}, {32'h0, 32'h80});

        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b_wait%0d", c), {61'h0, if_rvalid_b, stall_f_b, mem_en_b}, 64'h2);
        end

        @(posedge clk);
        @(negedge clk);
        chk("b_complete", {62'h0, if_rvalid_b, stall_f_b}, 64'h2);

        @(posedge clk); #1;
        if_req_b = 0;
        @(negedge clk);
        chk("b_after", {62'h0, if_rvalid_b, mem_en_b}, 64'h0);

        @(posedge clk); #1;
        if_req_a = 0; dm_req_a = 0;
        @(negedge clk);
        chk("a_if_queue_drained", 64'(iq_a.size()), 64'h0);
        chk("a_dm_queue_drained", 64'(dq_a.size()), 64'h0);
        chk("b_if_queue_drained", 64'(iq_b.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
